// File: rtl/simple2_pipe.sv
// simple2_pipe: three-stage valid/ready pipeline computing a NAND/NOR/XOR function of two operands.
module simple2_pipe #(
   parameter int WIDTH = 8,
   parameter int MODE  = 0,
   parameter int CNT_W = 8
) (
   input  logic             iccad_clk,
   input  logic             iccad_rst,
   input  logic [WIDTH-1:0] inp1,
   input  logic [WIDTH-1:0] inp2,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] res_cnt
);
   logic             v1, v2, adv1, adv2, adv3;
   logic [WIDTH-1:0] n1, a, res, fb, res_nx;
   // a stage may advance when it is empty or the stage below advances
   always_comb begin
      adv3   = !out_valid || out_ready;
      adv2   = !v2 || adv3;
      adv1   = !v1 || adv2;
      res_nx = ~(n1 | (MODE == 1 ? fb : a)) ^ n1;
   end
   assign in_ready = adv1;
   always_ff @(posedge iccad_clk) begin
      if (iccad_rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
         out       <= '0;
         n1        <= '0;
         a         <= '0;
         res       <= '0;
         fb        <= '0;
         res_cnt   <= '0;
      end else begin
         if (out_valid && out_ready) res_cnt <= res_cnt + 1'b1;
         if (adv3) begin
            out_valid <= v2;
            if (v2) out <= res;
         end
         if (adv2) begin
            v2 <= v1;
            if (v1) begin
               res <= res_nx;
               if (MODE == 1) fb <= res_nx;
            end
         end
         if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
               n1 <= ~(inp1 & inp2);
               a  <= inp1;
            end
         end
      end
   end
endmodule

// File: tb/tb_simple2_pipe.sv
// tb_simple2_pipe: bench for simple2_pipe with a MODE 0 (CNT_W=2) and a MODE 1 instance sharing stimulus.
module tb_simple2_pipe;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] inp1 = '0, inp2 = '0;
   logic       in_valid = 1'b0, out_ready = 1'b1;
   logic       ir0, ir1, ov0, ov1;
   logic [3:0] out0, out1;
   logic [1:0] cnt0;
   logic [7:0] cnt1;
   int n_lit = 0, f_lit = 0, n_mod = 0, f_mod = 0;
   bit armed = 1'b0;
   logic [3:0] q0[$], q1[$];
   logic [3:0] fb_m = '0;
   int m_cnt0 = 0, m_cnt1 = 0;
   always #5 clk = ~clk;
   simple2_pipe #(.WIDTH(4), .MODE(0), .CNT_W(2)) u0 (
      .iccad_clk(clk), .iccad_rst(rst), .inp1(inp1), .inp2(inp2), .in_valid(in_valid),
      .in_ready(ir0), .out(out0), .out_valid(ov0), .out_ready(out_ready), .res_cnt(cnt0));
   simple2_pipe #(.WIDTH(4), .MODE(1), .CNT_W(8)) u1 (
      .iccad_clk(clk), .iccad_rst(rst), .inp1(inp1), .inp2(inp2), .in_valid(in_valid),
      .in_ready(ir1), .out(out1), .out_valid(ov1), .out_ready(out_ready), .res_cnt(cnt1));
   function automatic logic [3:0] f(input logic [3:0] x, input logic [3:0] y, input logic [3:0] z);
      logic [3:0] n1;
      n1 = ~(x & y);
      return ~(n1 | z) ^ n1;
   endfunction
   task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_lit++;
      if (act !== exp) begin
         f_lit++;
         $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
      end
   endtask
   task automatic mod(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_mod++;
      if (act !== exp) begin
         f_mod++;
         $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
      end
   endtask
   // Model: a result is fixed at acceptance time (fb updates in acceptance order)
   always @(negedge clk) begin
      if (armed) begin
         mod("cnt0", {30'd0, cnt0}, m_cnt0 % 4);
         mod("cnt1", {24'd0, cnt1}, m_cnt1 % 256);
         if (q0.size() == 0) mod("ov0_empty", {31'd0, ov0}, 0);
         if (q1.size() == 0) mod("ov1_empty", {31'd0, ov1}, 0);
         if (ov0) mod("out0", {28'd0, out0}, q0.size() ? {28'd0, q0[0]} : 32'hdead);
         if (ov1) mod("out1", {28'd0, out1}, q1.size() ? {28'd0, q1[0]} : 32'hdead);
         if (q0.size() >= 3 && !out_ready) mod("ir0_full", {31'd0, ir0}, 0);
         if (q1.size() >= 3 && !out_ready) mod("ir1_full", {31'd0, ir1}, 0);
         if (q0.size() == 0) mod("ir0_empty", {31'd0, ir0}, 1);
      end
      if (rst) begin
         q0.delete();
         q1.delete();
         fb_m = '0;
         m_cnt0 = 0;
         m_cnt1 = 0;
      end else begin
         if (ov0 && out_ready && q0.size()) begin void'(q0.pop_front()); m_cnt0++; end
         if (ov1 && out_ready && q1.size()) begin void'(q1.pop_front()); m_cnt1++; end
         if (in_valid && ir0) q0.push_back(f(inp1, inp2, inp1));
         if (in_valid && ir1) begin
            fb_m = f(inp1, inp2, fb_m);
            q1.push_back(fb_m);
         end
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      int exp_cnt[8] = '{0, 0, 0, 1, 2, 3, 0, 1};
      int acc, cyc;
      step();
      step();
      armed = 1'b1;
      lit("rst_ov0", {31'd0, ov0}, 0);
      lit("rst_cnt0", {30'd0, cnt0}, 0);
      lit("rst_out0", {28'd0, out0}, 0);
      lit("rst_cnt1", {24'd0, cnt1}, 0);
      rst = 1'b0;
      inp1 = 4'b1100; inp2 = 4'b1010; in_valid = 1'b1;
      lit("ir_after_rst", {31'd0, ir0}, 1);
      step();
      in_valid = 1'b0;
      lit("lat_t0", {31'd0, ov0}, 0);
      step();
      lit("lat_t1", {31'd0, ov0}, 0);
      step();
      lit("lat_t2_ov", {31'd0, ov0}, 1);
      lit("m0_out", {28'd0, out0}, 32'b0111);
      lit("m1_first", {28'd0, out1}, 32'b1111);
      step();
      lit("cnt_one", {30'd0, cnt0}, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      in_valid = 1'b1;
      step();
      step();
      in_valid = 1'b0;
      step();
      lit("m1_b2b_a", {28'd0, out1}, 32'b1111);
      step();
      lit("m1_b2b_b", {28'd0, out1}, 32'b0111);
      lit("m1_b2b_ov", {31'd0, ov1}, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         in_valid = k < 5;
         inp1 = 4'(k);
         inp2 = 4'(15 - k);
         step();
         lit("cnt_wrap", {30'd0, cnt0}, exp_cnt[k]);
      end
      acc = 0;
      cyc = 0;
      while (acc < 10 && cyc < 300) begin
         out_ready = 1'($urandom_range(0, 1));
         in_valid = $urandom_range(0, 3) != 0;
         inp1 = in_valid ? 4'(acc + 3) : 4'($urandom);
         inp2 = in_valid ? 4'(9 - acc) : 4'($urandom);
         if (in_valid && ir0) acc++;
         step();
         cyc++;
      end
      lit("stream_accepted", acc, 10);
      in_valid = 1'b0;
      out_ready = 1'b1;
      cyc = 0;
      while ((q0.size() || q1.size()) && cyc < 20) begin
         step();
         cyc++;
      end
      lit("drain", q0.size() + q1.size(), 0);
      out_ready = 1'b0;
      in_valid = 1'b1;
      repeat (3) step();
      in_valid = 1'b0;
      lit("full_ir", {31'd0, ir0}, 0);
      lit("full_ov", {31'd0, ov0}, 1);
      rst = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      step();
      rst = 1'b0;
      in_valid = 1'b0;
      lit("midrst_ov", {31'd0, ov0}, 0);
      lit("midrst_cnt0", {30'd0, cnt0}, 0);
      lit("midrst_cnt1", {24'd0, cnt1}, 0);
      inp1 = 4'b1100; inp2 = 4'b1010; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      lit("midrst_fb", {28'd0, out1}, 32'b1111);
      lit("midrst_ov1", {31'd0, ov1}, 1);
      step();
      $display("TB_RESULT checks=%0d failures=%0d", n_lit + n_mod, f_lit + f_mod);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/simple2_pipe.md
SIMPLE2_PIPE -- requirements
Module: simple2_pipe

Interface
REQ-001 Parameter WIDTH, default 8: bit width of inp1, inp2 and out.
REQ-002 Parameter MODE, default 0: 0 = feed-forward function; 1 = registered-feedback function.
REQ-003 Parameter CNT_W, default 8: width of res_cnt.
REQ-004 iccad_clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 iccad_rst  input  1  reset, synchronous, active-high.
REQ-006 inp1  input  WIDTH  operand A.
REQ-007 inp2  input  WIDTH  operand B.
REQ-008 in_valid  input  1  operand pair valid.
REQ-009 in_ready  output  1  block can accept an operand pair this cycle.
REQ-010 out  output  WIDTH  result.
REQ-011 out_valid  output  1  out holds a valid result.
REQ-012 out_ready  input  1  consumer accepts out this cycle.
REQ-013 res_cnt  output  CNT_W  count of results handed off.

Function
REQ-014 Three register stages (S1, S2, S3), each holding a valid bit; S3 drives out/out_valid directly from registers.
REQ-015 Transfer rule: input accepted on an edge where in_valid && in_ready; output handed off on an edge where out_valid && out_ready.
REQ-016 Stage Sk loads when it is empty or its content moves downstream on the same edge; in_ready = !S1.v || S1 moves (combinational, no dependence on in_valid).
REQ-017 S1 load: n1 = ~(inp1 & inp2), also stores a = inp1, bitwise.
REQ-018 S2 load, MODE 0: n2 = ~(n1 | a); res = n2 ^ n1.
REQ-019 S2 load, MODE 1: n2 = ~(n1 | fb); res = n2 ^ n1; fb <= res on that same edge.
REQ-020 fb is a WIDTH-bit register, updated only on S2 loads in MODE 1, constant 0 in MODE 0.
REQ-021 S3 load copies res to out; out holds its value while out_valid && !out_ready.
REQ-022 Latency: with out_ready=1 and no stall, operand accepted on edge t appears with out_valid=1 after edge t+2; throughput one result per cycle.
REQ-023 Back-pressure: out_ready=0 with all stages full deasserts in_ready in that cycle; no data lost, duplicated or reordered.
REQ-024 Simultaneous handoff and fill: S3 full, out_ready=1, S2 full -> S3 reloads on the same edge, out_valid stays 1.
REQ-025 Bubbles: a stage emptied with no upstream data clears its valid; out is don't-care while out_valid=0.
REQ-026 res_cnt increments by 1 on each output handoff, wraps from 2^CNT_W-1 to 0.
REQ-027 Operand values sampled when in_valid=0 have no effect on any state, including fb.

Reset
REQ-028 iccad_rst=1 at an edge: all stage valid bits 0, out = 0, out_valid = 0, fb = 0, res_cnt = 0.
REQ-029 in_ready = 1 in the first cycle after reset release.
REQ-030 Reset mid-operation discards all in-flight data; no handoff occurs on the reset edge, and res_cnt does not increment.
REQ-031 Reset overrides simultaneous in_valid/out_ready on the same edge.

Verification
REQ-032 WIDTH=4, MODE 0, out_ready=1: inp1=4'b1100, inp2=4'b1010 accepted at edge t -> out=4'b0111, out_valid=1 after edge t+2, res_cnt=1.
REQ-033 WIDTH=4, MODE 1, after reset: the same pair sent twice back-to-back -> out=4'b1111, then 4'b0111 on consecutive cycles.
REQ-034 Stream of 10 distinct pairs, out_ready toggled 1/0 pseudo-randomly -> results arrive in order, none lost or duplicated, and in_ready=0 whenever all three stages are full and out_ready=0.
REQ-035 CNT_W=2: 5 handoffs -> res_cnt sequence 1,2,3,0,1.
REQ-036 iccad_rst asserted for one edge with 3 results in flight -> out_valid=0, res_cnt=0, fb=0 next cycle, and a following MODE 1 pair (4'b1100, 4'b1010) gives 4'b1111.
